// File: rtl/blk_89bc04.sv
// blk_89bc04: packet-granular arbiter merging the four RX class streams
// (cr=0, cw=1, rc=2, cfg=3) into one registered AXI4-Stream tagged with tdest.
module blk_89bc04 #(
    parameter int    C_DATA_WIDTH   = 32,
    parameter int    STRB_WIDTH     = C_DATA_WIDTH / 8,
    parameter int    C_RR_BURST     = 1,
    parameter string C_CFG_PRIORITY = "FALSE",
    parameter int    TCQ            = 1
) (
    input  logic                    com_iclk,
    input  logic                    com_sysrst_n,
    input  logic                    trn_lnk_up,

    input  logic [C_DATA_WIDTH-1:0] s_axis_cr_tdata,
    input  logic                    s_axis_cr_tvalid,
    output logic                    s_axis_cr_tready,
    input  logic [STRB_WIDTH-1:0]   s_axis_cr_tstrb,
    input  logic                    s_axis_cr_tlast,
    input  logic [21:0]             s_axis_cr_tuser,

    input  logic [C_DATA_WIDTH-1:0] s_axis_cw_tdata,
    input  logic                    s_axis_cw_tvalid,
    output logic                    s_axis_cw_tready,
    input  logic [STRB_WIDTH-1:0]   s_axis_cw_tstrb,
    input  logic                    s_axis_cw_tlast,
    input  logic [21:0]             s_axis_cw_tuser,

    input  logic [C_DATA_WIDTH-1:0] s_axis_rc_tdata,
    input  logic                    s_axis_rc_tvalid,
    output logic                    s_axis_rc_tready,
    input  logic [STRB_WIDTH-1:0]   s_axis_rc_tstrb,
    input  logic                    s_axis_rc_tlast,
    input  logic [21:0]             s_axis_rc_tuser,

    input  logic [C_DATA_WIDTH-1:0] s_axis_cfg_tdata,
    input  logic                    s_axis_cfg_tvalid,
    output logic                    s_axis_cfg_tready,
    input  logic [STRB_WIDTH-1:0]   s_axis_cfg_tstrb,
    input  logic                    s_axis_cfg_tlast,
    input  logic [21:0]             s_axis_cfg_tuser,

    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [STRB_WIDTH-1:0]   m_axis_tstrb,
    output logic                    m_axis_tlast,
    output logic [21:0]             m_axis_tuser,
    output logic [1:0]              m_axis_tdest,
    output logic                    arb_busy
);

    // Elaboration-time legality checks; TCQ is a simulation-only clock-to-Q
    // figure and never turns into a delay in this synthesizable code.
    if (C_RR_BURST < 1 || C_RR_BURST > 15) begin : g_bad_burst
        $error("C_RR_BURST must be in 1..15");
    end
    if (C_DATA_WIDTH != 32 && C_DATA_WIDTH != 64 && C_DATA_WIDTH != 128) begin : g_bad_width
        $error("C_DATA_WIDTH must be 32, 64 or 128");
    end
    if (TCQ < 0) begin : g_bad_tcq
        $error("TCQ must not be negative");
    end

    localparam bit         CFG_PRIO  = (C_CFG_PRIORITY == "TRUE");
    localparam logic [3:0] BURST_MAX = 4'(C_RR_BURST);

    typedef enum logic {IDLE, XFER} state_t;

    state_t     state, state_nxt;
    logic [1:0] grant, grant_nxt;
    logic       last_vld, last_vld_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic [1:0] rr_ptr, rr_nxt;

    logic [3:0]              in_valid;
    logic [3:0]              in_last;
    logic [C_DATA_WIDTH-1:0] in_data [4];
    logic [STRB_WIDTH-1:0]   in_strb [4];
    logic [21:0]             in_user [4];

    logic       out_ready;
    logic       accept;
    logic [3:0] src_ready;
    logic       rr_found;
    logic [1:0] rr_pick;
    logic [1:0] cand;
    logic       regrant_ok;
    logic [1:0] pick;
    logic       same_src;

    assign in_valid = {s_axis_cfg_tvalid, s_axis_rc_tvalid, s_axis_cw_tvalid, s_axis_cr_tvalid};
    assign in_last  = {s_axis_cfg_tlast, s_axis_rc_tlast, s_axis_cw_tlast, s_axis_cr_tlast};

    assign in_data[0] = s_axis_cr_tdata;
    assign in_data[1] = s_axis_cw_tdata;
    assign in_data[2] = s_axis_rc_tdata;
    assign in_data[3] = s_axis_cfg_tdata;
    assign in_strb[0] = s_axis_cr_tstrb;
    assign in_strb[1] = s_axis_cw_tstrb;
    assign in_strb[2] = s_axis_rc_tstrb;
    assign in_strb[3] = s_axis_cfg_tstrb;
    assign in_user[0] = s_axis_cr_tuser;
    assign in_user[1] = s_axis_cw_tuser;
    assign in_user[2] = s_axis_rc_tuser;
    assign in_user[3] = s_axis_cfg_tuser;

    // The output register can take a beat when empty or being drained this cycle.
    assign out_ready = ~m_axis_tvalid | m_axis_tready;
    assign accept    = (state == XFER) && in_valid[grant] && out_ready;
    assign arb_busy  = (state == XFER);

    // Only the granted source sees ready, and only while a packet is in flight.
    always_comb begin
        src_ready = 4'b0000;
        if (state == XFER) begin
            src_ready[grant] = out_ready;
        end
    end

    assign s_axis_cr_tready  = src_ready[0];
    assign s_axis_cw_tready  = src_ready[1];
    assign s_axis_rc_tready  = src_ready[2];
    assign s_axis_cfg_tready = src_ready[3];

    // Round-robin search: first valid source at or above rr_ptr, wrapping mod 4.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = rr_ptr;
        cand     = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!rr_found && in_valid[cand]) begin
                rr_found = 1'b1;
                rr_pick  = cand;
            end
        end
    end

    // Winner selection: strict CFG first, then burst continuation, then round-robin.
    always_comb begin
        regrant_ok = last_vld && in_valid[grant] && (burst_cnt < BURST_MAX);
        if (CFG_PRIO && in_valid[3]) begin
            pick = 2'd3;
        end else if (regrant_ok) begin
            pick = grant;
        end else begin
            pick = rr_pick;
        end
        same_src = last_vld && (pick == grant);
    end

    // Next-state logic: grants are only taken in IDLE and held until tlast is accepted.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_vld_nxt = last_vld;
        burst_nxt    = burst_cnt;
        rr_nxt       = rr_ptr;
        case (state)
            IDLE: begin
                if (trn_lnk_up && (|in_valid)) begin
                    state_nxt    = XFER;
                    grant_nxt    = pick;
                    last_vld_nxt = 1'b1;
                    if (same_src) begin
                        burst_nxt = (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 4'd1;
                    end else begin
                        burst_nxt = 4'd1;
                        rr_nxt    = pick + 2'd1;
                    end
                end
            end
            XFER: begin
                if (accept && in_last[grant]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
        if (!com_sysrst_n) begin
            state     <= IDLE;
            grant     <= 2'd0;
            last_vld  <= 1'b0;
            burst_cnt <= 4'd0;
            rr_ptr    <= 2'd0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            last_vld  <= last_vld_nxt;
            burst_cnt <= burst_nxt;
            rr_ptr    <= rr_nxt;
        end
    end

    // Output register: load on every accepted beat, empty once the consumer takes it.
    always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
        if (!com_sysrst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tstrb  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tdest  <= 2'd0;
        end else if (accept) begin
            m_axis_tdata  <= in_data[grant];
            m_axis_tvalid <= 1'b1;
            m_axis_tstrb  <= in_strb[grant];
            m_axis_tlast  <= in_last[grant];
            m_axis_tuser  <= in_user[grant];
            m_axis_tdest  <= grant;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_blk_89bc04.sv
// tb_blk_89bc04: directed bench for the RX arbiter (128-bit, burst 3, CFG priority).
module tb_blk_89bc04;

    localparam int DW = 128;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic lnk_up;
    logic m_ready;

    int src_npkt [4];
    int src_len  [4];
    int src_pkt  [4];
    int src_beat [4];

    logic [3:0]    s_valid;
    logic [3:0]    s_last;
    logic [3:0]    s_ready;
    logic [DW-1:0] s_data [4];
    logic [SW-1:0] s_strb [4];
    logic [21:0]   s_user [4];

    logic          cr_ready, cw_ready, rc_ready, cfg_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic [SW-1:0] m_strb;
    logic          m_last;
    logic [21:0]   m_user;
    logic [1:0]    m_dest;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [3:0]    snap_ready;
    logic          snap_mvalid;
    logic          snap_busy;
    logic [DW-1:0] snap_mdata;

    int            obs_dest [$];
    logic [DW-1:0] obs_data [$];
    logic          obs_last [$];
    logic [21:0]   obs_user [$];
    logic [SW-1:0] obs_strb [$];

    assign s_ready = {cfg_ready, rc_ready, cw_ready, cr_ready};

    function automatic logic [DW-1:0] patData(int s, int p, int b);
        logic [31:0] w;
        w = {8'hA0 + 8'(s), 8'(p), 8'(b), 8'h5C};
        return {w ^ 32'h1111_1111, w ^ 32'h2222_2222, w ^ 32'h4444_4444, w};
    endfunction

    function automatic logic [21:0] patUser(int s, int p, int b);
        return {6'(s), 8'(p), 8'(b)};
    endfunction

    function automatic logic [SW-1:0] patStrb(int s, int p, int b);
        return {8'(p) ^ 8'(s), 8'(b) ^ 8'hC3};
    endfunction

    // Source models: each presents its current beat while packets remain.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s_valid[i] = (src_pkt[i] < src_npkt[i]);
            s_last[i]  = (src_beat[i] == src_len[i] - 1);
            s_data[i]  = patData(i, src_pkt[i], src_beat[i]);
            s_strb[i]  = patStrb(i, src_pkt[i], src_beat[i]);
            s_user[i]  = patUser(i, src_pkt[i], src_beat[i]);
        end
    end

    blk_89bc04 #(
        .C_DATA_WIDTH  (DW),
        .C_RR_BURST    (3),
        .C_CFG_PRIORITY("TRUE"),
        .TCQ           (1)
    ) dut (
        .com_iclk         (clk),
        .com_sysrst_n     (rst_n),
        .trn_lnk_up       (lnk_up),
        .s_axis_cr_tdata  (s_data[0]),
        .s_axis_cr_tvalid (s_valid[0]),
        .s_axis_cr_tready (cr_ready),
        .s_axis_cr_tstrb  (s_strb[0]),
        .s_axis_cr_tlast  (s_last[0]),
        .s_axis_cr_tuser  (s_user[0]),
        .s_axis_cw_tdata  (s_data[1]),
        .s_axis_cw_tvalid (s_valid[1]),
        .s_axis_cw_tready (cw_ready),
        .s_axis_cw_tstrb  (s_strb[1]),
        .s_axis_cw_tlast  (s_last[1]),
        .s_axis_cw_tuser  (s_user[1]),
        .s_axis_rc_tdata  (s_data[2]),
        .s_axis_rc_tvalid (s_valid[2]),
        .s_axis_rc_tready (rc_ready),
        .s_axis_rc_tstrb  (s_strb[2]),
        .s_axis_rc_tlast  (s_last[2]),
        .s_axis_rc_tuser  (s_user[2]),
        .s_axis_cfg_tdata (s_data[3]),
        .s_axis_cfg_tvalid(s_valid[3]),
        .s_axis_cfg_tready(cfg_ready),
        .s_axis_cfg_tstrb (s_strb[3]),
        .s_axis_cfg_tlast (s_last[3]),
        .s_axis_cfg_tuser (s_user[3]),
        .m_axis_tdata     (m_data),
        .m_axis_tvalid    (m_valid),
        .m_axis_tready    (m_ready),
        .m_axis_tstrb     (m_strb),
        .m_axis_tlast     (m_last),
        .m_axis_tuser     (m_user),
        .m_axis_tdest     (m_dest),
        .arb_busy         (busy)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // One clock: sample at the falling edge, then advance sources and log consumed beats.
    task automatic applyStimulus(input int n);
        logic [3:0]    hs;
        logic          took;
        int            t_dest;
        logic [DW-1:0] t_data;
        logic          t_last;
        logic [21:0]   t_user;
        logic [SW-1:0] t_strb;
        repeat (n) begin
            @(negedge clk);
            snap_ready  = s_ready;
            snap_mvalid = m_valid;
            snap_busy   = busy;
            snap_mdata  = m_data;
            hs     = s_valid & s_ready;
            took   = m_valid & m_ready;
            t_dest = int'(m_dest);
            t_data = m_data;
            t_last = m_last;
            t_user = m_user;
            t_strb = m_strb;
            @(posedge clk);
            #1;
            if (took) begin
                obs_dest.push_back(t_dest);
                obs_data.push_back(t_data);
                obs_last.push_back(t_last);
                obs_user.push_back(t_user);
                obs_strb.push_back(t_strb);
            end
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    if (src_beat[i] == src_len[i] - 1) begin
                        src_beat[i] = 0;
                        src_pkt[i]++;
                    end else begin
                        src_beat[i]++;
                    end
                end
            end
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4; i++) begin
            src_npkt[i] = 0;
            src_len[i]  = 1;
            src_pkt[i]  = 0;
            src_beat[i] = 0;
        end
        obs_dest.delete();
        obs_data.delete();
        obs_last.delete();
        obs_user.delete();
        obs_strb.delete();
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        lnk_up  = 1'b1;
        m_ready = 1'b1;
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitBeats(input int n, input int budget);
        int c;
        c = 0;
        while (obs_dest.size() < n && c < budget) begin
            applyStimulus(1);
            c++;
        end
    endtask

    task automatic checkBeat(input int k, input int s, input int p, input int b, input logic last);
        checkOutput($sformatf("beat%0d_present", k), obs_dest.size() > k, 1'b1);
        if (obs_dest.size() > k) begin
            checkOutput($sformatf("beat%0d_dest", k), obs_dest[k], s);
            checkOutput($sformatf("beat%0d_data", k), obs_data[k], patData(s, p, b));
            checkOutput($sformatf("beat%0d_last", k), obs_last[k], last);
            checkOutput($sformatf("beat%0d_user", k), obs_user[k], patUser(s, p, b));
            checkOutput($sformatf("beat%0d_strb", k), obs_strb[k], patStrb(s, p, b));
        end
    endtask

    int t2_src [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    int t2_pkt [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 3};
    int t3_src [7]  = '{0, 0, 0, 2, 2, 2, 0};
    int t3_pkt [7]  = '{0, 1, 2, 0, 1, 2, 3};

    initial begin
        int c;

        // Reset state
        doReset();
        checkOutput("rst_mvalid", m_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_src_ready", s_ready, 4'b0000);
        checkOutput("rst_mdest", m_dest, 2'd0);
        checkOutput("rst_mlast", m_last, 1'b0);
        checkOutput("rst_mdata", m_data, '0);
        checkOutput("rst_muser", m_user, '0);

        // Round-robin with 2-beat packets and a burst limit of 3
        $display("[TB] round-robin");
        doReset();
        src_len[0] = 2; src_npkt[0] = 4;
        src_len[1] = 2; src_npkt[1] = 3;
        src_len[2] = 2; src_npkt[2] = 3;
        waitBeats(20, 120);
        for (int k = 0; k < 20; k++) begin
            checkBeat(k, t2_src[k / 2], t2_pkt[k / 2], k % 2, (k % 2) == 1);
        end

        // Burst: single-beat packets from CR and RC
        $display("[TB] burst");
        doReset();
        src_npkt[0] = 4;
        src_npkt[2] = 3;
        waitBeats(7, 60);
        for (int k = 0; k < 7; k++) begin
            checkBeat(k, t3_src[k], t3_pkt[k], 0, 1'b1);
        end

        // CFG priority: CFG arrives in the middle of CW packet 1
        $display("[TB] cfg priority");
        doReset();
        src_len[1] = 4; src_npkt[1] = 3;
        c = 0;
        while (!(src_pkt[1] == 1 && src_beat[1] == 1) && c < 100) begin
            applyStimulus(1);
            c++;
        end
        checkOutput("cfg_midpkt_reached", (src_pkt[1] == 1 && src_beat[1] == 1), 1'b1);
        src_len[3] = 1; src_npkt[3] = 2;
        waitBeats(14, 120);
        for (int k = 0; k < 8; k++) begin
            checkBeat(k, 1, k / 4, k % 4, (k % 4) == 3);
        end
        checkBeat(8, 3, 0, 0, 1'b1);
        checkBeat(9, 3, 1, 0, 1'b1);
        for (int k = 10; k < 14; k++) begin
            checkBeat(k, 1, 2, k - 10, k == 13);
        end

        // Backpressure: consumer ready goes 1,0,0,1 during a 4-beat RC packet
        $display("[TB] backpressure");
        doReset();
        src_len[2] = 4; src_npkt[2] = 1;
        applyStimulus(1);
        checkOutput("bp_idle_rc_ready", snap_ready[2], 1'b0);
        applyStimulus(1);
        checkOutput("bp_first_rc_ready", snap_ready[2], 1'b1);
        m_ready = 1'b1;
        applyStimulus(1);
        checkOutput("bp_c2_data", snap_mdata, patData(2, 0, 0));
        m_ready = 1'b0;
        applyStimulus(1);
        checkOutput("bp_c3_rc_ready", snap_ready[2], 1'b0);
        checkOutput("bp_c3_mvalid", snap_mvalid, 1'b1);
        checkOutput("bp_c3_data", snap_mdata, patData(2, 0, 1));
        applyStimulus(1);
        checkOutput("bp_c4_rc_ready", snap_ready[2], 1'b0);
        checkOutput("bp_c4_data", snap_mdata, patData(2, 0, 1));
        m_ready = 1'b1;
        applyStimulus(1);
        checkOutput("bp_c5_rc_ready", snap_ready[2], 1'b1);
        checkOutput("bp_c5_data", snap_mdata, patData(2, 0, 1));
        waitBeats(4, 20);
        for (int k = 0; k < 4; k++) begin
            checkBeat(k, 2, 0, k, k == 3);
        end

        // Link down during a 5-beat CR packet with CW waiting
        $display("[TB] link down");
        doReset();
        src_len[0] = 5; src_npkt[0] = 1;
        src_len[1] = 1; src_npkt[1] = 1;
        c = 0;
        while (src_beat[0] != 2 && c < 20) begin
            applyStimulus(1);
            c++;
        end
        lnk_up = 1'b0;
        applyStimulus(12);
        checkOutput("lnk_beat_count", obs_dest.size(), 5);
        for (int k = 0; k < 5; k++) begin
            checkBeat(k, 0, 0, k, k == 4);
        end
        checkOutput("lnk_down_busy", snap_busy, 1'b0);
        checkOutput("lnk_down_cw_ready", snap_ready[1], 1'b0);
        lnk_up = 1'b1;
        applyStimulus(1);
        checkOutput("lnk_up_decide_busy", snap_busy, 1'b0);
        applyStimulus(1);
        checkOutput("lnk_up_grant_busy", snap_busy, 1'b1);
        checkOutput("lnk_up_cw_ready", snap_ready[1], 1'b1);
        waitBeats(6, 10);
        checkBeat(5, 1, 0, 0, 1'b1);

        // Asynchronous reset in the middle of a CW packet
        $display("[TB] reset mid-packet");
        doReset();
        src_len[1] = 4; src_npkt[1] = 1;
        waitBeats(1, 20);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_mvalid", m_valid, 1'b0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_src_ready", s_ready, 4'b0000);
        clearModel();
        src_len[1] = 1; src_npkt[1] = 1;
        src_len[2] = 1; src_npkt[2] = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitBeats(2, 20);
        checkBeat(0, 1, 0, 0, 1'b1);
        checkBeat(1, 2, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blk_89bc04.md
Name: axi_enhanced_pcie_v1_04_a_axi_enhanced_rx_arbiter

Overview:
- Packet-granular arbiter that merges the four RX class streams (CR, CW, RC, CFG) into one AXI4-Stream. The shared consumer is a single-ingress bridge.
- Sits downstream of the RX demux. Preserves packet atomicity and tags every beat with its source class.
- Round-robin with configurable burst length and optional strict CFG priority. Registered output stage.

Parameters:
- C_DATA_WIDTH, 32, stream width; legal values 32/64/128.
- STRB_WIDTH, C_DATA_WIDTH/8, tstrb width; derived, do not override.
- C_RR_BURST, 1, max consecutive packets granted to one source while another source is valid; legal range 1..15.
- C_CFG_PRIORITY, "FALSE", "TRUE" makes CFG win every arbitration when valid and exempts it from the burst limit.
- TCQ, 1, clock-to-Q delay.

Ports:
- com_iclk  in  1  user clock.
- com_sysrst_n  in  1  asynchronous active-low reset.
- trn_lnk_up  in  1  link up; low blocks new grants.
- s_axis_X_tdata  in  C_DATA_WIDTH  source data, X in {cr,cw,rc,cfg}; source index cr=0, cw=1, rc=2, cfg=3.
- s_axis_X_tvalid  in  1  source valid.
- s_axis_X_tready  out  1  source ready.
- s_axis_X_tstrb  in  STRB_WIDTH  source byte enables.
- s_axis_X_tlast  in  1  source end of packet.
- s_axis_X_tuser  in  22  source sideband.
- m_axis_tdata  out  C_DATA_WIDTH  merged data.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  consumer ready.
- m_axis_tstrb  out  STRB_WIDTH  merged byte enables.
- m_axis_tlast  out  1  merged end of packet.
- m_axis_tuser  out  22  merged sideband.
- m_axis_tdest  out  2  source index of the current beat.
- arb_busy  out  1  high while the FSM is in XFER.

Behaviour:
- Reset: asynchronous assert, synchronous-release usage. All outputs 0. FSM=IDLE, rr_ptr=0, burst_cnt=0, output register empty.
- FSM states: IDLE, XFER.
- IDLE: if trn_lnk_up=1 and any s_*_tvalid=1, register grant[1:0] and go to XFER next cycle.
- IDLE priority order:
  - CFG first, if C_CFG_PRIORITY="TRUE" and CFG is valid.
  - Otherwise, if the last-granted source is valid and burst_cnt<C_RR_BURST, regrant it.
  - Otherwise, search from rr_ptr upward, modulo 4, for the first valid source.
- IDLE counters:
  - burst_cnt := burst_cnt+1 on a regrant of the same source, else 1.
  - rr_ptr := grant+1 mod 4 whenever the granted source differs from the last granted.
- XFER:
  - Only the granted source has tready = out_ready, where out_ready = ~m_axis_tvalid | m_axis_tready. All other tready=0.
  - On an accepted source beat, load the output register: data, strb, last, user, tdest=grant. m_axis_tvalid=1.
  - If m_axis_tready=1 and no new load occurs, m_axis_tvalid clears.
  - On an accepted source beat with tlast=1, go to IDLE.
- Latency:
  - 1 cycle from an accepted source beat to m_axis_tvalid.
  - Grant decision: 1 cycle after the first tvalid.
  - Minimum 1 idle cycle between packets at the source side. The output keeps full throughput within a packet.
- Atomicity:
  - A grant is never changed mid-packet, including when trn_lnk_up falls. The packet drains fully.
  - Source tvalid dropping mid-packet only stalls; the grant is held.
- Single-beat packet (tvalid and tlast in the same beat) is legal. FSM is in XFER for 1 accepted beat only.
- Simultaneous events: output load and consumer take in the same cycle keep m_axis_tvalid=1 with the new beat (no bubble).
- Backpressure: m_axis_tready=0 with the register full holds all m_axis_* stable and drives the granted tready=0.
- No source sees tready=1 while in IDLE.
- Counter widths: burst_cnt is 4 bits and saturates at C_RR_BURST. rr_ptr is 2 bits and wraps 3→0.
- Reset mid-packet: outputs clear immediately (async). Sources must restart the packet.

Test Plan:
- Round-robin: CR, CW, RC all continuously valid with 2-beat packets, C_RR_BURST=1 → tdest sequence 0,1,2,0,1,2; tlast on every 2nd beat; no interleaving.
- Burst: C_RR_BURST=3, CR and RC valid with 1-beat packets → tdest 0,0,0,2,2,2,0; burst_cnt resets on switch.
- CFG priority: C_CFG_PRIORITY="TRUE", CW streaming 4-beat packets, CFG asserts mid-packet 2 → CW packet completes, next grant is 3 on every arbitration while CFG is valid.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat RC packet (C_DATA_WIDTH=128) → data unchanged while stalled, all 4 beats delivered in order, s_axis_rc_tready=0 on stall cycles.
- Link down: trn_lnk_up falls on beat 2 of a 5-beat CR packet → all 5 beats delivered, then no grant while CW is valid; regrant 1 cycle after trn_lnk_up=1.
- Reset: com_sysrst_n pulsed low mid-packet → m_axis_tvalid=0, arb_busy=0 immediately; after release rr_ptr=0, first grant goes to lowest valid index.
